// File: rtl/axis_sync_pkt_fifo.sv
// -----------------------------------------------------------------------------
// axis_sync_pkt_fifo
//
// Single-clock AXI-Stream FIFO for {tdata, tkeep, tlast} with first-word
// fall-through output, occupancy (level) and stored-packet (pkt_count) status.
//
// Optional build macro: AXIS_FIFO_PKT_MODE_EN
//   undefined : cut-through; m_tvalid whenever the FIFO holds a beat.
//   defined   : store-and-forward; m_tvalid only once a complete packet
//               (a beat with tlast) is stored, or when the FIFO is full so an
//               oversize packet cannot deadlock.
//
// Parameters
//   DATA_WIDTH : tdata width in bits (multiple of 8)
//   ADDR_DEPTH : log2 of the number of entries
//
// Ports
//   aclk, areset_n           clock, asynchronous active-low reset
//   s_tdata/s_tkeep/s_tlast  ingress beat
//   s_tvalid / s_tready      ingress handshake (s_tready is a register)
//   m_tdata/m_tkeep/m_tlast  egress beat, zero whenever m_tvalid is low
//   m_tvalid / m_tready      egress handshake
//   level                    entries stored, 0..DEPTH
//   pkt_count                stored entries carrying tlast
// -----------------------------------------------------------------------------
module axis_sync_pkt_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_DEPTH = 4
) (
    input  logic                    aclk,
    input  logic                    areset_n,
    input  logic [DATA_WIDTH-1:0]   s_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_tkeep,
    input  logic                    s_tlast,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    output logic [DATA_WIDTH-1:0]   m_tdata,
    output logic [DATA_WIDTH/8-1:0] m_tkeep,
    output logic                    m_tlast,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic [ADDR_DEPTH:0]     level,
    output logic [ADDR_DEPTH:0]     pkt_count
);

    localparam int KEEP_WIDTH  = DATA_WIDTH / 8;
    localparam int DEPTH       = 2 ** ADDR_DEPTH;
    localparam int ENTRY_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

    localparam logic [ADDR_DEPTH:0]   LEVEL_FULL = (ADDR_DEPTH + 1)'(DEPTH);
    localparam logic [ADDR_DEPTH:0]   LEVEL_ONE  = (ADDR_DEPTH + 1)'(1);
    localparam logic [ADDR_DEPTH-1:0] PTR_ONE    = ADDR_DEPTH'(1);

    // Storage: entry layout is {tdata, tkeep, tlast}.
    logic [ENTRY_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_DEPTH-1:0] wr_ptr_reg;
    logic [ADDR_DEPTH-1:0] rd_ptr_reg;
    logic [ADDR_DEPTH:0]   level_reg;
    logic [ADDR_DEPTH:0]   level_next;
    logic [ADDR_DEPTH:0]   pkt_count_reg;
    logic [ADDR_DEPTH:0]   pkt_count_next;
    logic                  s_tready_reg;

    logic                  push;
    logic                  pop;
    logic                  m_tvalid_int;
    logic [ENTRY_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] head_data;
    logic [KEEP_WIDTH-1:0] head_keep;
    logic                  head_last;
    logic                  pkt_inc;
    logic                  pkt_dec;

    // Head of queue is read asynchronously so the oldest beat is presented
    // in the cycle right after it is written (fall-through).
    assign head      = mem[rd_ptr_reg];
    assign head_data = head[ENTRY_WIDTH-1 -: DATA_WIDTH];
    assign head_keep = head[KEEP_WIDTH:1];
    assign head_last = head[0];

`ifdef AXIS_FIFO_PKT_MODE_EN
    // Release only complete packets; a full FIFO also releases so a packet
    // longer than the storage streams out instead of deadlocking.
    assign m_tvalid_int = (level_reg != '0) &&
                          ((pkt_count_reg != '0) || (level_reg == LEVEL_FULL));
`else
    assign m_tvalid_int = (level_reg != '0);
`endif

    // s_tready_reg is already low at full, so push never overflows; pop is
    // gated by m_tvalid_int, so it never underflows.
    assign push    = s_tvalid & s_tready_reg;
    assign pop     = m_tvalid_int & m_tready;
    assign pkt_inc = push & s_tlast;
    assign pkt_dec = pop & head_last;

    always_comb begin
        level_next = level_reg;
        unique case ({push, pop})
            2'b10:   level_next = level_reg + LEVEL_ONE;
            2'b01:   level_next = level_reg - LEVEL_ONE;
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        pkt_count_next = pkt_count_reg;
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_count_next = pkt_count_reg + LEVEL_ONE;
            2'b01:   pkt_count_next = pkt_count_reg - LEVEL_ONE;
            default: pkt_count_next = pkt_count_reg;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            level_reg     <= '0;
            pkt_count_reg <= '0;
            s_tready_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            level_reg     <= level_next;
            pkt_count_reg <= pkt_count_next;
            // Looking at level_next lets a pop at full reopen the input on
            // the very next cycle without depending on m_tready combinationally.
            s_tready_reg  <= (level_next != LEVEL_FULL);
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {s_tdata, s_tkeep, s_tlast};
        end
    end

    // Egress beat is masked to zero per byte lane whenever it is not valid.
    genvar gi;
    generate
        for (gi = 0; gi < KEEP_WIDTH; gi++) begin : g_lane
            assign m_tdata[gi*8 +: 8] = m_tvalid_int ? head_data[gi*8 +: 8] : 8'h00;
            assign m_tkeep[gi]        = m_tvalid_int & head_keep[gi];
        end
    endgenerate

    assign m_tlast   = m_tvalid_int & head_last;
    assign m_tvalid  = m_tvalid_int;
    assign s_tready  = s_tready_reg;
    assign level     = level_reg;
    assign pkt_count = pkt_count_reg;

endmodule

// File: tb/tb_axis_sync_pkt_fifo.sv
// -----------------------------------------------------------------------------
// tb_axis_sync_pkt_fifo
//
// Randomised bench for axis_sync_pkt_fifo at default parameters (DEPTH=16).
// A queue of beats is the reference: every cycle the bench works out which
// handshakes happen from the queue contents and its own ready flag, then
// compares every DUT output against the queue on the falling edge.
// Packet-mode scenarios are compiled in when AXIS_FIFO_PKT_MODE_EN is defined.
// -----------------------------------------------------------------------------
module tb_axis_sync_pkt_fifo;

    localparam int DW    = 32;
    localparam int KW    = DW / 8;
    localparam int AD    = 4;
    localparam int DEPTH = 2 ** AD;
    localparam int NWRAP = 3 * DEPTH;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          aclk;
    logic          areset_n;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [AD:0]   level;
    logic [AD:0]   pkt_count;

    axis_sync_pkt_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_DEPTH (AD)
    ) dut (
        .aclk      (aclk),
        .areset_n  (areset_n),
        .s_tdata   (s_tdata),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tkeep   (m_tkeep),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .level     (level),
        .pkt_count (pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Reference state
    beat_t q[$];
    bit    exp_ready;
    bit    last_push;
    int    n_pops;
    int    n_last_pops;

    int    n_checks;
    int    n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int model_pkts();
        int c;
        c = 0;
        foreach (q[i]) if (q[i].l) c++;
        return c;
    endfunction

    function automatic bit model_valid();
`ifdef AXIS_FIFO_PKT_MODE_EN
        return (q.size() != 0) && ((model_pkts() != 0) || (q.size() == DEPTH));
`else
        return (q.size() != 0);
`endif
    endfunction

    task automatic compare_all();
        bit ev;
        ev = model_valid();
        check("s_tready", s_tready, exp_ready);
        check("level", level, q.size());
        check("pkt_count", pkt_count, model_pkts());
        check("m_tvalid", m_tvalid, ev);
        if (ev) begin
            check("m_tdata", m_tdata, q[0].d);
            check("m_tkeep", m_tkeep, q[0].k);
            check("m_tlast", m_tlast, q[0].l);
        end else begin
            check("m_tdata_idle", m_tdata, 0);
            check("m_tkeep_idle", m_tkeep, 0);
            check("m_tlast_idle", m_tlast, 0);
        end
    endtask

    // One clock: apply the handshake rules to the reference at the rising
    // edge, then compare at the falling edge.
    task automatic cycle();
        bit    push;
        bit    pop;
        beat_t b;
        @(posedge aclk);
        if (!areset_n) begin
            q.delete();
            exp_ready = 1'b0;
            last_push = 1'b0;
        end else begin
            push = s_tvalid && exp_ready;
            pop  = model_valid() && m_tready;
            if (pop) begin
                b = q.pop_front();
                n_pops++;
                if (b.l) n_last_pops++;
                $display("pop %0d: data=%08h keep=%h last=%0d level_before=%0d",
                         n_pops, b.d, b.k, b.l, q.size() + 1);
            end
            if (push) q.push_back('{d: s_tdata, k: s_tkeep, l: s_tlast});
            last_push = push;
            exp_ready = (q.size() != DEPTH);
        end
        @(negedge aclk);
        compare_all();
    endtask

    task automatic drain(input string tag);
        int g;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        g = 0;
        while (q.size() != 0 && g < 200) begin
            cycle();
            g++;
        end
        check(tag, level, 0);
    endtask

    beat_t wrap_in [NWRAP];
    int    idx;
    int    guard;
    int    pops0;
    bit    seen;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_pops    = 0;
        n_last_pops = 0;
        exp_ready = 1'b0;
        last_push = 1'b0;
        areset_n  = 1'b0;
        s_tdata   = '0;
        s_tkeep   = '0;
        s_tlast   = 1'b0;
        s_tvalid  = 1'b0;
        m_tready  = 1'b0;

        // Reset held for 3 cycles, then released.
        repeat (3) cycle();
        areset_n = 1'b1;
        cycle();
        check("rst_ready_after_release", s_tready, 1);
        check("rst_level", level, 0);

        // Fill with m_tready low: 0x00..0x10 offered, only 16 fit.
        m_tready = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < 17 && guard < 30) begin
            s_tvalid = 1'b1;
            s_tdata  = DW'(idx);
            s_tkeep  = '1;
            s_tlast  = (idx == 15);
            cycle();
            if (last_push) idx++;
            guard++;
        end
        check("fill_accepted", idx, 16);
        check("fill_level", level, 16);
        check("fill_ready_low", s_tready, 0);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        pops0 = n_pops;
        repeat (17) cycle();
        check("drain_pops", n_pops - pops0, 16);
        check("drain_valid_low", m_tvalid, 0);

        // Simultaneous push/pop at level 8.
        m_tready = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < 8 && guard < 30) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = KW'($urandom_range(0, 15));
            s_tlast  = 1'b1;
            cycle();
            if (last_push) idx++;
            guard++;
        end
        check("steady_prefill", level, 8);
        for (int i = 0; i < 100; i++) begin
            s_tvalid = 1'b1;
            m_tready = 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = KW'($urandom_range(0, 15));
`ifdef AXIS_FIFO_PKT_MODE_EN
            s_tlast  = 1'b1;
`else
            s_tlast  = 1'($urandom_range(0, 1));
`endif
            cycle();
            check("steady_level", level, 8);
        end
        drain("steady_drained");

        // Wrap: 3*DEPTH random beats, random valid and ready.
        for (int i = 0; i < NWRAP; i++) begin
            wrap_in[i].d = $urandom;
            wrap_in[i].k = KW'($urandom_range(0, 15));
            wrap_in[i].l = (i == NWRAP - 1) ? 1'b1 : 1'($urandom_range(0, 3) == 0);
        end
        pops0 = n_pops;
        idx   = 0;
        guard = 0;
        while ((idx < NWRAP || q.size() != 0) && guard < 3000) begin
            s_tvalid = (idx < NWRAP) && ($urandom_range(0, 3) != 0);
            if (idx < NWRAP) begin
                s_tdata = wrap_in[idx].d;
                s_tkeep = wrap_in[idx].k;
                s_tlast = wrap_in[idx].l;
            end
            m_tready = ($urandom_range(0, 2) != 0);
            cycle();
            if (last_push) idx++;
            guard++;
        end
        check("wrap_pushed", idx, NWRAP);
        check("wrap_popped", n_pops - pops0, NWRAP);
        s_tvalid = 1'b0;

`ifdef AXIS_FIFO_PKT_MODE_EN
        // Five-beat packet: held back until the tlast beat is stored.
        m_tready = 1'b1;
        for (int b = 0; b < 5; b++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = '1;
            s_tlast  = (b == 4);
            cycle();
            if (b < 4) check("pkt_hold", m_tvalid, 0);
        end
        check("pkt_count_one", pkt_count, 1);
        check("pkt_released", m_tvalid, 1);
        pops0 = n_last_pops;
        drain("pkt_drained");
        check("pkt_last_seen", n_last_pops - pops0, 1);
        check("pkt_count_zero", pkt_count, 0);

        // Oversize packet: 20 beats into 16 entries.
        pops0 = n_pops;
        seen  = 1'b0;
        idx   = 0;
        guard = 0;
        while (idx < 20 && guard < 200) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = KW'($urandom_range(0, 15));
            s_tlast  = (idx == 19);
            cycle();
            if (last_push) idx++;
            if (!seen && m_tvalid) begin
                seen = 1'b1;
                check("ovs_level_at_release", level, 16);
            end
            guard++;
        end
        drain("ovs_drained");
        check("ovs_pops", n_pops - pops0, 20);
`endif

        // Reset in the middle of traffic clears everything at once.
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tkeep  = '1;
            s_tlast  = (i == 2);
            cycle();
        end
        s_tvalid = 1'b0;
        check("midrst_level_before", level, 5);
        #2 areset_n = 1'b0;
        #1;
        q.delete();
        exp_ready = 1'b0;
        compare_all();
        repeat (2) cycle();
        areset_n = 1'b1;
        cycle();
        check("midrst_ready", s_tready, 1);
        check("midrst_level", level, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
